// File: rtl/slave_port.sv
// slave_port: serial write-frame receiver with slave-select decode.
// Optional sticky framing-error output under SP_FRAME_CHECK_EN.
module slave_port #(
  parameter logic [3:0] SLAVE_ID = 4'h1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        sp_addr,
  input  logic        sp_wdata,
  input  logic        sp_valid,
  output logic        sp_ready,
  output logic [11:0] s_addr,
  output logic [7:0]  s_wdata,
  output logic        s_valid,
  input  logic        s_ready
`ifdef SP_FRAME_CHECK_EN
  ,
  output logic        sp_frame_err
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    RX_SEL,
    RX_ADDR,
    RX_DATA,
    DROP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_sr_q, addr_sr_d;
  logic [7:0]  data_sr_q, data_sr_d;
  logic [11:0] s_addr_q, s_addr_d;
  logic [7:0]  s_wdata_q, s_wdata_d;
  logic        s_valid_q, s_valid_d;

  logic        in_frame;
  logic        abort;
  logic        beat_hs;
  logic        addr_shift;
  logic        data_shift;
  logic        sel_match;
  logic        deliver;
  logic        unused_sr;

  // Upper address bits are shifted through but only
  // the select nibble is consumed, on the fly.
  assign unused_sr = ^addr_sr_q[15:11];

  // A frame is live in the three receive states.
  assign in_frame = (state_q == RX_SEL) ||
                    (state_q == RX_ADDR) ||
                    (state_q == RX_DATA);

  assign abort     = in_frame && !sp_valid;
  assign beat_hs   = sp_valid && sp_ready;
  assign sel_match = ({addr_sr_q[2:0], sp_addr} == SLAVE_ID);

  // Select nibble is taken unconditionally; the rest
  // of the frame only moves on a valid/ready beat.
  assign addr_shift = ((state_q == IDLE) && sp_valid) ||
                      ((state_q == RX_SEL) && sp_valid) ||
                      ((state_q == RX_ADDR) && beat_hs) ||
                      ((state_q == RX_DATA) && beat_hs);

  assign data_shift = (state_q == RX_DATA) && beat_hs;
  assign deliver    = data_shift && (cnt_q == 4'd15);

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (sp_valid) state_d = RX_SEL;
      end
      RX_SEL: begin
        if (!sp_valid) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd3) begin
          state_d = sel_match ? RX_ADDR : DROP;
        end
      end
      RX_ADDR: begin
        if (!sp_valid) begin
          state_d = IDLE;
        end else if (sp_ready && (cnt_q == 4'd7)) begin
          state_d = RX_DATA;
        end
      end
      RX_DATA: begin
        if (!sp_valid) begin
          state_d = IDLE;
        end else if (sp_ready && (cnt_q == 4'd15)) begin
          state_d = IDLE;
        end
      end
      DROP: begin
        if (!sp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready to the bus; a pending request stalls
  // everything past the select nibble.
  always_comb begin
    sp_ready = 1'b0;
    if ((state_q == RX_ADDR) || (state_q == RX_DATA)) begin
      sp_ready = !s_valid_q;
    end
  end

  // Beat counter and shift-register next state.
  always_comb begin
    cnt_d     = cnt_q;
    addr_sr_d = addr_sr_q;
    data_sr_d = data_sr_q;
    if (abort) begin
      cnt_d = 4'd0;
    end else if ((state_q == IDLE) && sp_valid) begin
      cnt_d = 4'd1;
    end else if ((state_q == DROP) && !sp_valid) begin
      cnt_d = 4'd0;
    end else if (addr_shift) begin
      cnt_d = cnt_q + 4'd1;
    end
    if (addr_shift) begin
      addr_sr_d = {addr_sr_q[14:0], sp_addr};
    end
    if (data_shift) begin
      data_sr_d = {data_sr_q[6:0], sp_wdata};
    end
  end

  // Request to the slave: loaded on the final beat,
  // held until the slave takes it.
  always_comb begin
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    s_valid_d = s_valid_q;
    if (deliver) begin
      s_addr_d  = {addr_sr_q[10:0], sp_addr};
      s_wdata_d = {data_sr_q[6:0], sp_wdata};
      s_valid_d = 1'b1;
    end else if (s_valid_q && s_ready) begin
      s_valid_d = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q     <= 4'd0;
      addr_sr_q <= 16'd0;
      data_sr_q <= 8'd0;
      s_addr_q  <= 12'd0;
      s_wdata_q <= 8'd0;
      s_valid_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      addr_sr_q <= addr_sr_d;
      data_sr_q <= data_sr_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      s_valid_q <= s_valid_d;
    end
  end

  assign s_addr  = s_addr_q;
  assign s_wdata = s_wdata_q;
  assign s_valid = s_valid_q;

`ifdef SP_FRAME_CHECK_EN
  logic err_q;

  // Sticky abort flag; only reset clears it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_q <= 1'b0;
    end else if (abort) begin
      err_q <= 1'b1;
    end
  end

  assign sp_frame_err = err_q;
`endif

endmodule

// File: doc/slave_port.md
# slave_port

Bus-side receiver for the serial write protocol driven by the master ports. It deserializes one write frame: 16 address bits MSB first, with the 8 data bits MSB first on a separate line alongside the last 8 address bits. It decodes the upper 4 address bits as a slave select and presents a matched write to the local slave as a parallel valid/ready transaction. One instance sits between the bus fabric and each slave memory.

## Interface
- SLAVE_ID, 4'h1: value of address bits [15:12] this port responds to.
- clk  input  1  system clock; all state changes on rising edge.
- rstn  input  1  reset, asynchronous, active-low.
- sp_addr  input  1  serial address bit from bus, MSB first.
- sp_wdata  input  1  serial write-data bit from bus, MSB first; meaningful only during the data phase.
- sp_valid  input  1  frame in progress; high for the whole frame.
- sp_ready  output  1  receiver accepting address/data beats; combinational from state and s_valid.
- s_addr  output  12  received word address (frame address bits [11:0]).
- s_wdata  output  8  received write data.
- s_valid  output  1  write request to slave.
- s_ready  input  1  slave accepts request.
- sp_frame_err  output  1  sticky framing error; present only with SP_FRAME_CHECK_EN.

## Operation
- Shift registers: addr_sr[15:0] and data_sr[7:0], shifting left with the new bit inserted at the LSB. A 4-bit beat counter `cnt` counts sampled beats 0..15.
- States: IDLE, RX_SEL, RX_ADDR, RX_DATA, DROP.
- IDLE: if sp_valid=1, sample sp_addr as beat 0, set cnt=1, go to RX_SEL.
- RX_SEL: sample sp_addr every cycle sp_valid=1; sp_ready is ignored here and driven 0. On beat 3, compare {addr_sr[2:0],sp_addr} with SLAVE_ID. Match: go to RX_ADDR. Mismatch: go to DROP.
- RX_ADDR: beats 4..7. Sample sp_addr only when sp_valid && sp_ready. After beat 7, go to RX_DATA.
- RX_DATA: beats 8..15. Sample sp_addr and sp_wdata together on each sp_valid && sp_ready. After beat 15:
  - load s_addr = {addr_sr[10:0],sp_addr}
  - load s_wdata = {data_sr[6:0],sp_wdata}
  - set s_valid=1
  - go to IDLE.
- DROP: no sampling, sp_ready=0; return to IDLE on the first cycle with sp_valid=0.
- sp_ready = (state==RX_ADDR || state==RX_DATA) && !s_valid. A pending unaccepted request back-pressures the next frame after its select nibble.
- s_valid is cleared on the cycle s_valid && s_ready; s_addr and s_wdata hold until then.
- sp_valid falling in RX_SEL, RX_ADDR or RX_DATA aborts the frame: go to IDLE, cnt=0, and no s_valid is generated.

## Timing
- Reset (async, immediate): state=IDLE, cnt=0, shift registers 0, s_addr=0, s_wdata=0, s_valid=0, sp_ready=0, sp_frame_err=0.
- Select nibble: 4 consecutive cycles, unconditional.
- sp_ready rises combinationally in the first RX_ADDR cycle, i.e. the cycle after beat 3 is sampled, provided s_valid=0.
- Unstalled frame: 16 sp_valid cycles. s_valid rises the cycle after beat 15 is sampled.
- Minimum s_valid pulse: 1 cycle, when s_ready is held high.
- A new frame may start in the cycle right after the final beat. Its select nibble is received while the previous s_valid is still pending.
- Simultaneous events:
  - s_ready accepting in the same cycle a stall is in effect: sp_ready rises the next cycle.
  - Final beat sampled in the same cycle the prior request is accepted: cannot occur, because sp_ready=0 while s_valid=1.

## Configuration
- SP_FRAME_CHECK_EN defined: sp_frame_err port exists. It is set when sp_valid falls in RX_SEL, RX_ADDR or RX_DATA before beat 15, and cleared only by rstn. The aborted frame is discarded.
- SP_FRAME_CHECK_EN undefined: the port is absent. Aborts return silently to IDLE.

## Test plan
- Frame addr=16'h1A5C, data=8'h3E, s_ready=1, no stalls -> s_valid pulses 1 cycle after the 16th beat with s_addr=12'hA5C, s_wdata=8'h3E.
- Frame addr=16'h2123 with SLAVE_ID=1 -> sp_ready never rises, DROP until sp_valid falls, no s_valid; the next matching frame is received normally.
- Back-to-back frames 16'h1001/8'h11 then 16'h1002/8'h22 with s_ready=0 for 10 cycles -> the second frame stalls at beat 4 (sp_ready=0). It completes after the first is accepted, and the outputs show 12'h002/8'h22.
- Master holds sp_ready-dependent beats at random stall cycles -> the received word is unchanged versus the no-stall case (12'hA5C/8'h3E).
- sp_valid drops after beat 9 -> state returns to IDLE and no s_valid. With SP_FRAME_CHECK_EN, sp_frame_err=1 and stays 1.
- rstn asserted at beat 12 -> all outputs 0 immediately; a fresh frame after release decodes correctly.
